// File: rtl/cam_entry_manager.sv
// Entry allocator, write sequencer and hit encoder for a RAM-based ternary CAM.
// Optional: define CAM_SCRUB_ON_DELETE_EN to zero-write CAM entries on delete.
module cam_entry_manager #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [DATA_WIDTH-1:0]    req_data,
  input  logic [DATA_WIDTH-1:0]    req_care,
  output logic                     rsp_valid,
  output logic [1:0]               rsp_status,
  output logic [ADDR_WIDTH-1:0]    rsp_addr,
  output logic                     cam_start_write,
  output logic [ADDR_WIDTH-1:0]    cam_waddr,
  output logic [DATA_WIDTH-1:0]    cam_wdata,
  output logic [DATA_WIDTH-1:0]    cam_wcare,
  input  logic                     cam_ready,
  input  logic [(1<<ADDR_WIDTH)-1:0] cam_match_lines,
  output logic                     hit_found,
  output logic [ADDR_WIDTH-1:0]    hit_addr,
  output logic [ADDR_WIDTH:0]      free_count
);
  localparam int WORDS = 1 << ADDR_WIDTH;
  localparam logic [1:0] ST_OK = 2'b00;
  localparam logic [1:0] ST_FULL = 2'b01;
  localparam logic [1:0] ST_NV = 2'b10;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] CNT_ALL = (ADDR_WIDTH+1)'(WORDS);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP
  } state_t;

  state_t state, state_nx;
  logic [WORDS-1:0] valid;
  logic [WORDS-1:0] masked;
  logic [1:0] op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] care_q;
  logic accept, is_ins, is_clr;
  logic free_any;
  logic [ADDR_WIDTH-1:0] free_idx;
  logic [ADDR_WIDTH-1:0] hit_idx;

  assign req_ready = (state == IDLE) && !rst;
  assign accept = req_valid && req_ready;
  assign is_ins = (req_op == 2'b00);
  assign is_clr = (req_op == 2'b10);

  // Descending scan leaves the lowest qualifying index.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    hit_idx = '0;
    for (int i = WORDS-1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_any = 1'b1;
        free_idx = ADDR_WIDTH'(i);
      end
      if (masked[i]) hit_idx = ADDR_WIDTH'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (is_ins)
            state_nx = free_any ? ISSUE : RESP;
          else if (is_clr)
            state_nx = RESP;
          else if (valid[req_addr])
`ifdef CAM_SCRUB_ON_DELETE_EN
            state_nx = ISSUE;
`else
            state_nx = RESP;
`endif
          else
            state_nx = RESP;
        end
      end
      ISSUE:     if (cam_ready)  state_nx = WAIT_BUSY;
      WAIT_BUSY: if (!cam_ready) state_nx = WAIT_DONE;
      WAIT_DONE: if (cam_ready)  state_nx = RESP;
      RESP:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      free_count <= CNT_ALL;
      op_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      care_q <= '0;
      rsp_valid <= 1'b0;
      rsp_status <= ST_OK;
      rsp_addr <= '0;
      cam_start_write <= 1'b0;
      cam_waddr <= '0;
      cam_wdata <= '0;
      cam_wcare <= '0;
    end else begin
      cam_start_write <= 1'b0;
      rsp_valid <= (state == RESP);
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_q <= req_op;
            addr_q <= req_addr;
            data_q <= req_data;
            care_q <= req_care;
            if (is_ins) begin
              if (free_any) begin
                addr_q <= free_idx;
              end else begin
                rsp_status <= ST_FULL;
                rsp_addr <= '0;
              end
            end else if (is_clr) begin
              valid <= '0;
              free_count <= CNT_ALL;
              rsp_status <= ST_OK;
              rsp_addr <= '0;
            end else if (valid[req_addr]) begin
              valid[req_addr] <= 1'b0;
              free_count <= free_count + CNT_ONE;
              rsp_status <= ST_OK;
              rsp_addr <= req_addr;
              data_q <= '0;
              care_q <= '1;
            end else begin
              rsp_status <= ST_NV;
              rsp_addr <= req_addr;
            end
          end
        end
        ISSUE: begin
          if (cam_ready) begin
            cam_start_write <= 1'b1;
            cam_waddr <= addr_q;
            cam_wdata <= data_q;
            cam_wcare <= care_q;
          end
        end
        WAIT_DONE: begin
          if (cam_ready) begin
            if (op_q == 2'b00) begin
              valid[addr_q] <= 1'b1;
              free_count <= free_count - CNT_ONE;
            end
            rsp_status <= ST_OK;
            rsp_addr <= addr_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Lookup pipeline runs every cycle, independent of the request FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      masked <= '0;
      hit_found <= 1'b0;
      hit_addr <= '0;
    end else begin
      masked <= cam_match_lines & valid;
      hit_found <= |masked;
      hit_addr <= hit_idx;
    end
  end
endmodule
